// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/MEM shared single-port memory arbiter with starvation guard
module mem_port_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_ready,
    output logic                  if_stall,
    input  logic                  dm_read,
    input  logic                  dm_write,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  dm_ready,
    output logic                  dm_stall,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_read,
    output logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  err
);

    localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                state_q, state_d;
    logic [LAT_W-1:0]      lat_cnt_q, lat_cnt_d;
    logic [SC_W-1:0]       starve_cnt_q, starve_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  op_write_q, op_write_d;
    logic                  grant_dm_q, grant_dm_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
    logic                  err_q, err_d;

    logic dm_any;
    logic force_if;

    assign dm_any   = dm_read | dm_write;
    assign force_if = (starve_cnt_q == SC_W'(STARVE_LIMIT)) && if_req;

    // Next-state: arbitrate in IDLE, count out the access, one-cycle response
    always_comb begin
        state_d      = state_q;
        lat_cnt_d    = lat_cnt_q;
        starve_cnt_d = starve_cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        op_write_d   = op_write_q;
        grant_dm_d   = grant_dm_q;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        err_d        = err_q;
        case (state_q)
            IDLE: begin
                if (dm_any && !force_if) begin
                    state_d    = ACCESS;
                    grant_dm_d = 1'b1;
                    op_write_d = dm_write;
                    addr_d     = dm_addr;
                    wdata_d    = dm_wdata;
                    lat_cnt_d  = LAT_W'(MEM_LATENCY - 1);
                    if (dm_read && dm_write) begin
                        err_d = 1'b1;
                    end
                    if (!if_req) begin
                        starve_cnt_d = '0;
                    end else if (starve_cnt_q != SC_W'(STARVE_LIMIT)) begin
                        starve_cnt_d = starve_cnt_q + SC_W'(1);
                    end
                end else if (if_req) begin
                    state_d      = ACCESS;
                    grant_dm_d   = 1'b0;
                    op_write_d   = 1'b0;
                    addr_d       = if_addr;
                    wdata_d      = '0;
                    lat_cnt_d    = LAT_W'(MEM_LATENCY - 1);
                    starve_cnt_d = '0;
                end
            end
            ACCESS: begin
                if (lat_cnt_q == '0) begin
                    state_d = RESP;
                    if (!op_write_q) begin
                        if (grant_dm_q) begin
                            dm_rdata_d = mem_rdata;
                        end else begin
                            if_rdata_d = mem_rdata;
                        end
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any access in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            lat_cnt_q    <= '0;
            starve_cnt_q <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            op_write_q   <= 1'b0;
            grant_dm_q   <= 1'b0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            op_write_q   <= op_write_d;
            grant_dm_q   <= grant_dm_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
            err_q        <= err_d;
        end
    end

    // Outputs decode from state so reset drops the strobes without a clock edge
    always_comb begin
        mem_read  = (state_q == ACCESS) && !op_write_q;
        mem_write = (state_q == ACCESS) && op_write_q;
        mem_addr  = (state_q == ACCESS) ? addr_q : '0;
        mem_wdata = (state_q == ACCESS) ? wdata_q : '0;
        if_ready  = (state_q == RESP) && !grant_dm_q;
        dm_ready  = (state_q == RESP) && grant_dm_q;
        if_stall  = if_req & ~if_ready;
        dm_stall  = dm_any & ~dm_ready;
        if_rdata  = if_rdata_q;
        dm_rdata  = dm_rdata_q;
        err       = err_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ready, if_stall;
    logic        dm_read = 1'b0, dm_write = 1'b0;
    logic [31:0] dm_addr = '0, dm_wdata = '0;
    logic [31:0] dm_rdata;
    logic        dm_ready, dm_stall;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write, err;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_dm_rdata;

    mem_port_arbiter #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(2), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_ready(if_ready), .if_stall(if_stall),
        .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .dm_stall(dm_stall), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata),
        .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        case (a)
            32'h10:  return 32'h8C22_0004;
            32'h100: return 32'h0000_0005;
            default: return a ^ 32'hA5A5_0000;
        endcase
    endfunction

    assign mem_rdata = mem_read ? rd_model(mem_addr) : 32'h0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        checks++;
        if ({if_ready, dm_ready, mem_read, mem_write, err, if_rdata, dm_rdata, mem_addr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h exp 0",
                     {if_ready, dm_ready, mem_read, mem_write, err, if_rdata, dm_rdata, mem_addr});
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_access();
        int got;
        if_req = 1'b1; if_addr = 32'h40;
        tick();
        checks++;
        if (mem_read !== 1'b1 || mem_addr !== 32'h40) begin
            errors++;
            $display("FAIL rma_access: mem_read=%b addr=%h exp 1/40", mem_read, mem_addr);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (mem_read !== 1'b0) begin
            errors++;
            $display("FAIL rma_async_drop: mem_read=%b exp 0", mem_read);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (if_ready !== 1'b0) begin
                errors++;
                $display("FAIL rma_no_ready: if_ready=%b exp 0", if_ready);
            end
        end
        rst = 1'b1;
        got = 0;
        for (int i = 1; i <= 8 && got == 0; i++) begin
            tick();
            if (if_ready === 1'b1) got = i;
        end
        checks++;
        if (got != 3 || if_rdata !== rd_model(32'h40)) begin
            errors++;
            $display("FAIL rma_regrant: ready_cycle=%0d rdata=%h exp 3/%h", got, if_rdata, rd_model(32'h40));
        end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_single_fetch();
        if_req = 1'b1; if_addr = 32'h10;
        #1;
        checks++;
        if (if_stall !== 1'b1) begin
            errors++;
            $display("FAIL fetch_stall_start: got %b exp 1", if_stall);
        end
        for (int k = 1; k <= 2; k++) begin
            tick();
            checks++;
            if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 32'h10 || if_stall !== 1'b1 || if_ready !== 1'b0) begin
                errors++;
                $display("FAIL fetch_access%0d: rd=%b wr=%b addr=%h stall=%b rdy=%b exp 1/0/10/1/0",
                         k, mem_read, mem_write, mem_addr, if_stall, if_ready);
            end
        end
        tick();
        checks++;
        if (if_ready !== 1'b1 || if_rdata !== 32'h8C22_0004 || if_stall !== 1'b0 || mem_read !== 1'b0) begin
            errors++;
            $display("FAIL fetch_resp: rdy=%b rdata=%h stall=%b rd=%b exp 1/8c220004/0/0",
                     if_ready, if_rdata, if_stall, mem_read);
        end
        if_req = 1'b0;
        tick();
        checks++;
        if (if_ready !== 1'b0 || if_rdata !== 32'h8C22_0004) begin
            errors++;
            $display("FAIL fetch_hold: rdy=%b rdata=%h exp 0/8c220004", if_ready, if_rdata);
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] exp_addr [4] = '{32'h100, 32'h100, 32'h14, 32'h14};
        logic [31:0] seen [4];
        int n = 0;
        if_req = 1'b1; if_addr = 32'h14;
        dm_read = 1'b1; dm_addr = 32'h100;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if ((mem_read || mem_write) && n < 4) begin
                seen[n] = mem_addr;
                n++;
            end
            if (c == 3) begin
                checks++;
                if (dm_ready !== 1'b1 || if_ready !== 1'b0 || dm_rdata !== 32'h5) begin
                    errors++;
                    $display("FAIL sim_dm_first: dm_rdy=%b if_rdy=%b dm_rdata=%h exp 1/0/5", dm_ready, if_ready, dm_rdata);
                end
                dm_read = 1'b0;
            end
            if (c == 7) begin
                checks++;
                if (if_ready !== 1'b1 || if_rdata !== rd_model(32'h14)) begin
                    errors++;
                    $display("FAIL sim_if_second: rdy=%b rdata=%h exp 1/%h", if_ready, if_rdata, rd_model(32'h14));
                end
                if_req = 1'b0;
            end
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL sim_addr_count: got %0d exp 4", n);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (seen[i] !== exp_addr[i]) begin
                    errors++;
                    $display("FAIL sim_addr_seq[%0d]: got %h exp %h", i, seen[i], exp_addr[i]);
                end
            end
        end
        exp_dm_rdata = 32'h5;
        tick();
    endtask

    task automatic test_store();
        dm_write = 1'b1; dm_addr = 32'h20; dm_wdata = 32'hDEAD_BEEF;
        for (int k = 1; k <= 2; k++) begin
            tick();
            checks++;
            if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 32'h20 || mem_wdata !== 32'hDEAD_BEEF) begin
                errors++;
                $display("FAIL store_access%0d: wr=%b rd=%b addr=%h wdata=%h exp 1/0/20/deadbeef",
                         k, mem_write, mem_read, mem_addr, mem_wdata);
            end
        end
        tick();
        checks++;
        if (dm_ready !== 1'b1 || dm_rdata !== exp_dm_rdata || mem_write !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL store_resp: rdy=%b rdata=%h wr=%b err=%b exp 1/%h/0/0", dm_ready, dm_rdata, mem_write, err, exp_dm_rdata);
        end
        dm_write = 1'b0;
        tick();
    endtask

    task automatic test_starvation();
        int seq[$];
        int exp_seq [6] = '{1, 1, 1, 1, 0, 1};
        int n_dm = 0;
        if_req = 1'b1; if_addr = 32'h30;
        dm_read = 1'b1; dm_addr = 32'h200;
        for (int c = 0; c < 80 && seq.size() < 6; c++) begin
            tick();
            checks++;
            if (if_ready === 1'b1 && dm_ready === 1'b1) begin
                errors++;
                $display("FAIL starve_dual_ready: if_ready=%b dm_ready=%b exp not both", if_ready, dm_ready);
            end
            if (dm_ready === 1'b1) begin
                checks++;
                if (dm_rdata !== rd_model(32'h200 + 32'(4 * n_dm))) begin
                    errors++;
                    $display("FAIL starve_dm_rdata%0d: got %h exp %h", n_dm, dm_rdata, rd_model(32'h200 + 32'(4 * n_dm)));
                end
                n_dm++;
                seq.push_back(1);
                if (n_dm == 5) dm_read = 1'b0;
                else dm_addr = 32'h200 + 32'(4 * n_dm);
            end
            if (if_ready === 1'b1) begin
                checks++;
                if (if_rdata !== rd_model(32'h30)) begin
                    errors++;
                    $display("FAIL starve_if_rdata: got %h exp %h", if_rdata, rd_model(32'h30));
                end
                seq.push_back(0);
                if_req = 1'b0;
            end
        end
        checks++;
        if (seq.size() != 6) begin
            errors++;
            $display("FAIL starve_timeout: got %0d completions exp 6", seq.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (seq[i] != exp_seq[i]) begin
                    errors++;
                    $display("FAIL starve_order[%0d]: got %0d exp %0d (1=dm 0=if)", i, seq[i], exp_seq[i]);
                end
            end
        end
        exp_dm_rdata = rd_model(32'h210);
        if_req = 1'b0; dm_read = 1'b0;
        tick();
    endtask

    task automatic test_illegal_op();
        dm_read = 1'b1; dm_write = 1'b1; dm_addr = 32'h24; dm_wdata = 32'h1234_5678;
        tick();
        checks++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_wdata !== 32'h1234_5678 || err !== 1'b1) begin
            errors++;
            $display("FAIL illegal_access: wr=%b rd=%b wdata=%h err=%b exp 1/0/12345678/1", mem_write, mem_read, mem_wdata, err);
        end
        tick();
        tick();
        checks++;
        if (dm_ready !== 1'b1 || dm_rdata !== exp_dm_rdata) begin
            errors++;
            $display("FAIL illegal_resp: rdy=%b rdata=%h exp 1/%h", dm_ready, dm_rdata, exp_dm_rdata);
        end
        dm_read = 1'b0; dm_write = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL illegal_err_sticky: got %b exp 1", err);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL illegal_err_reset: got %b exp 0", err);
        end
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_reset_mid_access();
        test_single_fetch();
        test_simultaneous();
        test_store();
        test_starvation();
        test_illegal_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency unified memory between the IF stage (instruction fetch) and the MEM stage (data load/store) of the pipelined processor.
- Arbitrates requests, sequences multi-cycle memory accesses and returns read data with a one-cycle ready pulse.
- Produces per-requester stall signals, which the hazard unit ORs into pc_write / IF_ID_write and pipeline freeze.

Parameters:
- DATA_WIDTH, 32, memory word width.
- ADDR_WIDTH, 32, byte address width.
- MEM_LATENCY, 2, cycles a memory access must be held (must be ≥1).
- STARVE_LIMIT, 4, consecutive data grants tolerated while a fetch is pending.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held until if_ready.
- if_addr  in  ADDR_WIDTH  fetch address.
- if_rdata  out  DATA_WIDTH  fetched instruction, registered.
- if_ready  out  1  one-cycle completion pulse for fetch.
- if_stall  out  1  if_req & ~if_ready.
- dm_read  in  1  load request; held until dm_ready.
- dm_write  in  1  store request; held until dm_ready.
- dm_addr  in  ADDR_WIDTH  data address.
- dm_wdata  in  DATA_WIDTH  store data.
- dm_rdata  out  DATA_WIDTH  load data, registered.
- dm_ready  out  1  one-cycle completion pulse for data.
- dm_stall  out  1  (dm_read|dm_write) & ~dm_ready.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_rdata  in  DATA_WIDTH  memory read data, valid in the last access cycle.
- err  out  1  sticky; set when dm_read & dm_write are both high in IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - All outputs 0.
  - Latency counter and starvation counter cleared.
  - An access in progress is aborted immediately: mem_read and mem_write drop without waiting for a clock edge, and no ready pulse follows.
- State IDLE:
  - mem_read=mem_write=0.
  - Arbitration is sampled at the rising edge.
  - Grant DM if dm_read|dm_write, unless starve_cnt==STARVE_LIMIT and if_req=1, in which case grant IF.
  - Otherwise grant IF if if_req.
  - Otherwise stay in IDLE.
  - On any grant, latch addr, wdata and op into internal registers, load lat_cnt=MEM_LATENCY-1, and go to ACCESS.
- Starvation counter:
  - Increments on a DM grant while if_req=1, saturating at STARVE_LIMIT.
  - Clears on an IF grant.
  - Clears on a DM grant while if_req=0.
- dm_read & dm_write both high at arbitration:
  - Treated as a write.
  - err is set and stays set until reset.
- State ACCESS:
  - mem_addr and mem_wdata are driven from the latched registers; mem_read or mem_write=1 according to the latched op.
  - The access lasts exactly MEM_LATENCY cycles.
  - Requester inputs are ignored during ACCESS; changes have no effect.
  - lat_cnt decrements each cycle.
  - At the edge where lat_cnt==0:
    - Capture mem_rdata into if_rdata or dm_rdata (read accesses only; stores leave dm_rdata unchanged).
    - Go to RESP.
- State RESP:
  - Exactly one cycle.
  - The granted requester's ready=1; mem strobes are 0.
  - No arbitration occurs in RESP, so a requester dropping its request after ready cannot be double-granted.
  - Next state is IDLE.
- Latency: from the request-sampling edge in IDLE, ready is high during cycle MEM_LATENCY+1 after that edge. The memory is busy for MEM_LATENCY cycles and the port turnaround is 2 cycles (RESP + IDLE).
- Stall outputs: combinational from inputs and ready only. A stall stays high from request assertion through the cycle before the ready pulse.
- rdata registers hold their value until overwritten by the next read completion for the same requester.
- Only one of if_ready and dm_ready is ever high in a given cycle.
- Mem strobes are never both high.

Test Plan:
- Reset mid-access (MEM_LATENCY=2): assert if_req with addr 0x40, then pull rst=0 during ACCESS.
  - mem_read drops with no clock edge.
  - No if_ready pulse follows.
  - After release, the held request is re-granted from IDLE.
- Single fetch: if_req=1, if_addr=0x10, memory returns 0x8C220004.
  - mem_read=1 with mem_addr=0x10 for 2 cycles.
  - if_ready pulses 3 cycles after the sampling edge with if_rdata=0x8C220004.
  - if_stall=1 until the pulse.
- Simultaneous requests: if_req (0x14) and dm_read (0x100, mem returns 0x5) in the same cycle.
  - DM is served first: dm_rdata=0x5, dm_ready pulses.
  - IF is granted at the following IDLE edge.
  - mem_addr sequence is 0x100, 0x100, 0x14, 0x14.
- Store: dm_write=1, dm_addr=0x20, dm_wdata=0xDEADBEEF.
  - mem_write=1 for 2 cycles with that data.
  - dm_ready pulses.
  - dm_rdata is unchanged.
- Starvation (STARVE_LIMIT=4): hold if_req while issuing 5 back-to-back data loads.
  - Loads 1–4 are granted.
  - The fifth arbitration grants IF, after which the counter clears and the fifth load is served.
- Illegal op: dm_read=dm_write=1.
  - A write is performed.
  - err=1 and stays 1 until reset.
